uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- Parametrised multi-byte UART transmitter. Successor to the team's fixed 2-byte transmitter with its hard-coded inter-byte wait.
- Serialises NUM_BYTES bytes from one parallel word onto tx, LSB first. Each byte is framed as start bit, data bits, optional parity bit, then 1 or 2 stop bits.
- Inserts a configurable idle-high gap between consecutive bytes.
- Runs at one bit per clock on the bit-rate clock (9600 Hz domain). Sits between the sensor/data-formatting logic and the board TX pin.
- Adds a start/busy/done handshake and input latching, which the previous generation lacked.

Parameters:
- NUM_BYTES, 2: bytes per transmission, range 1..8.
- GAP_CYCLES, 4: idle-high bit periods inserted between bytes, range 0..15. Not applied after the last byte.
- PARITY_EN, 0: 1 = append a parity bit after the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Ignored when PARITY_EN = 0.
- STOP_BITS, 1: stop bits per byte, 1 or 2.

Ports:
- clk_9k6hz, input, 1: bit-rate clock. One bit period per rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: request a transmission. Sampled only in IDLE.
- data, input, NUM_BYTES*8: payload. Byte k is data[8k+7:8k]. Byte 0 is sent first.
- tx, output, 1: serial line. Idles high.
- busy, output, 1: high while a transmission is in progress.
- done, output, 1: one-cycle pulse when a transmission completes.

Behaviour:
- Reset (asynchronous, rst_n=0): tx=1, busy=0, done=0, state=IDLE, all counters cleared. A reset mid-frame aborts immediately with tx high. No partial completion and no done pulse.
- All outputs are registered.
- FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
- IDLE:
  - tx=1, busy=0.
  - On an edge with start=1: latch data into the shift register, set byte_idx=0, tx<=0, busy<=1, go to START.
  - The start bit is therefore visible for the bit period following the accepting edge.
- START: one period of tx=0. Next edge: tx<=bit0 of the current byte, go to DATA.
- DATA:
  - 8 periods, bits 0..7 in order.
  - After bit 7: go to PARITY if PARITY_EN, otherwise STOP.
  - Parity is computed over the 8 latched bits of the current byte. Even: tx = XOR of the bits. Odd: tx = inverted XOR.
- PARITY: one period. Next edge goes to STOP.
- STOP:
  - STOP_BITS periods of tx=1.
  - Then, if byte_idx < NUM_BYTES-1: increment byte_idx and go to GAP if GAP_CYCLES>0, otherwise directly to START (tx<=0).
  - If the last byte is finished: go to IDLE, busy<=0, done<=1 for exactly one cycle.
- GAP: GAP_CYCLES periods of tx=1, counted down to zero. Then tx<=0 and go to START.
- busy timing: busy=1 from the accepting edge until the edge that returns the FSM to IDLE.
- Total busy duration: NUM_BYTES*(9+PARITY_EN+STOP_BITS) + (NUM_BYTES-1)*GAP_CYCLES cycles. Defaults give 24.
- start while busy: ignored, no queuing.
- data changes while busy: no effect. The word latched at acceptance is the one transmitted.
- start=1 on the cycle done pulses: not accepted, because the FSM is not yet in IDLE. Accepted on the next edge. Consecutive frames are therefore separated by at least one idle-high period.
- start held high continuously: frames repeat back-to-back with that one idle period between them.
- Counter widths: bit counter 3 bits, gap counter 4 bits, byte_idx $clog2(NUM_BYTES) bits (minimum 1). No wrap-around is permitted. Every counter terminates at its compare value.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (3-bit encoding);
  - a function frame_bits(PARITY_EN, STOP_BITS) returning 9+PARITY_EN+STOP_BITS;
  - constants TX_IDLE=1'b1, TX_START=1'b0.
- One sub-module is natural: uart_byte_shifter, which provides the byte load, LSB-first shift, bit counter and running parity. The top level keeps the FSM, byte index, gap counter and handshake.

Test Plan:
1. Defaults, data=16'hA53C, one start pulse:
   - tx sequence: 0 | 0,0,1,1,1,1,0,0 | 1 | 1,1,1,1 | 0 | 1,0,1,0,0,1,0,1 | 1.
   - busy high for 24 cycles, then done pulses once.
2. PARITY_EN=1, PARITY_ODD=0, data=16'h013C:
   - parity bit 0 after byte 0x3C and 1 after byte 0x01.
   - Repeat with PARITY_ODD=1: parity bits become 1 and 0.
3. NUM_BYTES=3, GAP_CYCLES=0, STOP_BITS=2, data=24'hFF00AA:
   - no gap between bytes; exactly 2 high periods after each byte.
   - busy lasts 33 cycles.
4. Pulse start, change data 3 cycles later, pulse start again mid-frame:
   - transmitted bits match the originally latched word;
   - second start ignored; exactly one done pulse.
5. Assert rst_n=0 mid-way through byte 0's data bits:
   - tx=1, busy=0 asynchronously, before the next clock edge; no done pulse.
   - After release, a new start transmits a full, correct frame.
6. start held high for 60 cycles with defaults:
   - two complete frames, separated by exactly one idle-high cycle;
   - done pulses twice, each one cycle wide.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the multi-byte UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_GAP    = 3'd5
  } state_e;

  localparam logic TX_IDLE  = 1'b1;
  localparam logic TX_START = 1'b0;

  // Bit periods occupied by one framed byte: start + 8 data + parity + stop.
  function automatic int unsigned frame_bits(input int unsigned parity_en,
                                             input int unsigned stop_bits);
    return 32'd9 + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/uart_byte_shifter.sv
// One-byte LSB-first shifter with a 3-bit bit counter and running parity.
module uart_byte_shifter
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_byte,
  input  logic       shift,
  input  logic       count,
  output logic       bit_out,
  output logic       last_bit,
  output logic       parity
);

  logic [7:0] shreg_q, shreg_d;
  logic [2:0] cnt_q, cnt_d;
  logic       par_q, par_d;

  // Load restarts the byte; each shift folds the outgoing bit into the parity.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    if (load) begin
      shreg_d = load_byte;
      cnt_d   = 3'd0;
      par_d   = 1'b0;
    end else begin
      if (shift) begin
        shreg_d = {1'b0, shreg_q[7:1]};
        par_d   = par_q ^ shreg_q[0];
      end else begin
        shreg_d = shreg_q;
        par_d   = par_q;
      end
      if (count && (cnt_q != 3'd7)) begin
        cnt_d = cnt_q + 3'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // Shifter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= 8'h00;
      cnt_q   <= 3'd0;
      par_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
    end
  end

  assign bit_out  = shreg_q[0];
  assign last_bit = (cnt_q == 3'd7);
  assign parity   = par_q;

endmodule

// File: rtl/uart_tx_frame.sv
// Multi-byte UART transmitter: framing FSM, byte index, inter-byte gap and
// start/busy/done handshake around a single-byte shifter.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned NUM_BYTES  = 2,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                   clk_9k6hz,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NUM_BYTES*8-1:0] data,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int unsigned FRAME_LEN = frame_bits(PARITY_EN, STOP_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic       STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic       PAR_ODD   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  if ((NUM_BYTES < 1) || (NUM_BYTES > 8) || (GAP_CYCLES > 15) || (PARITY_EN > 1) ||
      (PARITY_ODD > 1) || (STOP_BITS < 1) || (STOP_BITS > 2) ||
      (FRAME_LEN < 10) || (FRAME_LEN > 12)) begin : g_bad_cfg
    $error("uart_tx_frame: parameter out of range");
  end

  state_e                 state_q, state_d;
  logic [NUM_BYTES*8-1:0] data_q, data_d;
  logic [IDX_W-1:0]       byte_idx_q, byte_idx_d;
  logic [3:0]             gap_q, gap_d;
  logic                   stop_q, stop_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [IDX_W-1:0] next_idx_s;
  logic [7:0]       next_byte_s;
  logic             sh_load_s, sh_shift_s, sh_count_s;
  logic [7:0]       sh_byte_s;
  logic             sh_bit_s, sh_last_s, sh_par_s;

  // Byte that follows the current one in the latched word.
  always_comb begin
    next_idx_s  = byte_idx_q + 1'b1;
    next_byte_s = 8'h00;
    for (int k = 0; k < int'(NUM_BYTES); k++) begin
      next_byte_s = (IDX_W'(k) == next_idx_s) ? data_q[8*k +: 8] : next_byte_s;
    end
  end

  // Frame sequencing: next state, next outputs and shifter controls.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    byte_idx_d = byte_idx_q;
    gap_d      = gap_q;
    stop_d     = stop_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sh_load_s  = 1'b0;
    sh_shift_s = 1'b0;
    sh_count_s = 1'b0;
    sh_byte_s  = next_byte_s;

    case (state_q)
      ST_IDLE: begin
        tx_d   = TX_IDLE;
        busy_d = 1'b0;
        if (start) begin
          data_d     = data;
          byte_idx_d = '0;
          sh_load_s  = 1'b1;
          sh_byte_s  = data[7:0];
          tx_d       = TX_START;
          busy_d     = 1'b1;
          state_d    = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        tx_d       = sh_bit_s;
        sh_shift_s = 1'b1;
        state_d    = ST_DATA;
      end
      ST_DATA: begin
        if (sh_last_s) begin
          if (PARITY_EN != 0) begin
            tx_d    = sh_par_s ^ PAR_ODD;
            state_d = ST_PARITY;
          end else begin
            tx_d    = TX_IDLE;
            stop_d  = 1'b0;
            state_d = ST_STOP;
          end
        end else begin
          tx_d       = sh_bit_s;
          sh_shift_s = 1'b1;
          sh_count_s = 1'b1;
        end
      end
      ST_PARITY: begin
        tx_d    = TX_IDLE;
        stop_d  = 1'b0;
        state_d = ST_STOP;
      end
      ST_STOP: begin
        if (stop_q == STOP_LAST) begin
          if (byte_idx_q == LAST_IDX) begin
            tx_d    = TX_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            byte_idx_d = next_idx_s;
            if (GAP_CYCLES > 0) begin
              tx_d    = TX_IDLE;
              gap_d   = GAP_LOAD;
              state_d = ST_GAP;
            end else begin
              tx_d      = TX_START;
              sh_load_s = 1'b1;
              state_d   = ST_START;
            end
          end
        end else begin
          tx_d   = TX_IDLE;
          stop_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == 4'd0) begin
          tx_d      = TX_START;
          sh_load_s = 1'b1;
          sh_byte_s = data_q[8*byte_idx_q +: 8];
          state_d   = ST_START;
        end else begin
          tx_d  = TX_IDLE;
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        tx_d    = TX_IDLE;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers; reset aborts any frame with the line idle.
  always_ff @(posedge clk_9k6hz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      byte_idx_q <= '0;
      gap_q      <= 4'd0;
      stop_q     <= 1'b0;
      tx_q       <= TX_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      byte_idx_q <= byte_idx_d;
      gap_q      <= gap_d;
      stop_q     <= stop_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  uart_byte_shifter u_shifter (
    .clk       (clk_9k6hz),
    .rst_n     (rst_n),
    .load      (sh_load_s),
    .load_byte (sh_byte_s),
    .shift     (sh_shift_s),
    .count     (sh_count_s),
    .bit_out   (sh_bit_s),
    .last_bit  (sh_last_s),
    .parity    (sh_par_s)
  );

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations checked against a bit-list
// reference model built directly from the framing rules.
module tb_uart_tx_frame;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s [4];
  logic [63:0] data_v  [4];
  logic        tx_w    [4];
  logic        busy_w  [4];
  logic        done_w  [4];

  int vectors    = 0;
  int miscompares = 0;

  int nb_a  [4] = '{2, 2, 2, 3};
  int gap_a [4] = '{4, 4, 4, 0};
  int pe_a  [4] = '{0, 1, 1, 0};
  int po_a  [4] = '{0, 0, 1, 0};
  int sb_a  [4] = '{1, 1, 1, 2};

  typedef struct {
    int          sel;
    logic [63:0] data;
    int          exp_len;
  } vec_t;

  vec_t vec_tab [4];
  bit   exp_q [$];

  always #5 clk = ~clk;

  uart_tx_frame u_def (
    .clk_9k6hz(clk), .rst_n(rst_n), .start(start_s[0]), .data(data_v[0][15:0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));

  uart_tx_frame #(.PARITY_EN(1), .PARITY_ODD(0)) u_pe (
    .clk_9k6hz(clk), .rst_n(rst_n), .start(start_s[1]), .data(data_v[1][15:0]),
    .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));

  uart_tx_frame #(.PARITY_EN(1), .PARITY_ODD(1)) u_po (
    .clk_9k6hz(clk), .rst_n(rst_n), .start(start_s[2]), .data(data_v[2][15:0]),
    .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

  uart_tx_frame #(.NUM_BYTES(3), .GAP_CYCLES(0), .STOP_BITS(2)) u_3b (
    .clk_9k6hz(clk), .rst_n(rst_n), .start(start_s[3]), .data(data_v[3][23:0]),
    .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3]));

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s[%0d]: got %0h, want %0h", name, idx, act, exp_v);
    end
  endtask

  // Expected line level for every bit period of one transmission.
  task automatic build_expected(input int sel, input logic [63:0] d);
    logic [7:0] b;
    exp_q.delete();
    for (int k = 0; k < nb_a[sel]; k++) begin
      b = d[8*k +: 8];
      exp_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
      if (pe_a[sel] != 0) exp_q.push_back((^b) ^ po_a[sel][0]);
      for (int i = 0; i < sb_a[sel]; i++) exp_q.push_back(1'b1);
      if (k < nb_a[sel] - 1)
        for (int i = 0; i < gap_a[sel]; i++) exp_q.push_back(1'b1);
    end
  endtask

  task automatic run_frame(input int sel, input logic [63:0] d, input int exp_len,
                           input bit disturb);
    logic e;
    build_expected(sel, d);
    @(negedge clk);
    data_v[sel]  = d;
    start_s[sel] = 1'b1;
    @(negedge clk);
    start_s[sel] = 1'b0;
    for (int i = 0; i < exp_len; i++) begin
      e = (i < exp_q.size()) ? exp_q[i] : 1'b1;
      chk("tx", i, 32'(tx_w[sel]), 32'(e));
      chk("busy", i, 32'(busy_w[sel]), 32'd1);
      chk("done_early", i, 32'(done_w[sel]), 32'd0);
      if (disturb && i == 2) begin
        data_v[sel]  = ~d;
        start_s[sel] = 1'b1;
      end
      if (disturb && i == 3) start_s[sel] = 1'b0;
      @(negedge clk);
    end
    chk("busy_end", sel, 32'(busy_w[sel]), 32'd0);
    chk("done_pulse", sel, 32'(done_w[sel]), 32'd1);
    chk("tx_end", sel, 32'(tx_w[sel]), 32'd1);
    @(negedge clk);
    chk("done_width", sel, 32'(done_w[sel]), 32'd0);
    chk("busy_idle", sel, 32'(busy_w[sel]), 32'd0);
  endtask

  initial begin
    int ph, done_cnt;
    bit seen;
    logic [63:0] d;

    vec_tab[0] = '{0, 64'h0000_0000_0000_A53C, 24};
    vec_tab[1] = '{1, 64'h0000_0000_0000_013C, 26};
    vec_tab[2] = '{2, 64'h0000_0000_0000_013C, 26};
    vec_tab[3] = '{3, 64'h0000_0000_00FF_00AA, 33};

    rst_n = 1'b0;
    for (int s = 0; s < 4; s++) begin
      start_s[s] = 1'b0;
      data_v[s]  = 64'd0;
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      chk("rst_tx", s, 32'(tx_w[s]), 32'd1);
      chk("rst_busy", s, 32'(busy_w[s]), 32'd0);
      chk("rst_done", s, 32'(done_w[s]), 32'd0);
    end
    #1 rst_n = 1'b1;

    for (int v = 0; v < 4; v++)
      run_frame(vec_tab[v].sel, vec_tab[v].data, vec_tab[v].exp_len, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < 4; s++) begin
        d = {$urandom, $urandom};
        d = d & ((64'd1 << (8 * nb_a[s])) - 64'd1);
        run_frame(s, d, vec_tab[s].exp_len, 1'b0);
      end
    end

    // Data change and a second start mid-frame must not disturb the frame.
    run_frame(0, 64'h0000_0000_0000_C381, 24, 1'b1);

    // Asynchronous reset in the middle of byte 0 data bits.
    @(negedge clk);
    data_v[0]  = 64'h0000_0000_0000_5AC3;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_tx", 0, 32'(tx_w[0]), 32'd1);
    chk("arst_busy", 0, 32'(busy_w[0]), 32'd0);
    chk("arst_done", 0, 32'(done_w[0]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_hold_done", i, 32'(done_w[0]), 32'd0);
      chk("arst_hold_tx", i, 32'(tx_w[0]), 32'd1);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", 0, 32'(done_w[0]), 32'd0);
    run_frame(0, 64'h0000_0000_0000_5AC3, 24, 1'b0);

    // start held high: frames every 25 periods, done in the idle period.
    d = 64'h0000_0000_0000_A53C;
    build_expected(0, d);
    @(negedge clk);
    data_v[0]  = d;
    start_s[0] = 1'b1;
    @(negedge clk);
    done_cnt = 0;
    for (int p = 0; p < 60; p++) begin
      ph = p % 25;
      if (ph < 24) begin
        chk("hold_tx", p, 32'(tx_w[0]), 32'(exp_q[ph]));
        chk("hold_busy", p, 32'(busy_w[0]), 32'd1);
        chk("hold_done", p, 32'(done_w[0]), 32'd0);
      end else begin
        chk("hold_gap_tx", p, 32'(tx_w[0]), 32'd1);
        chk("hold_gap_busy", p, 32'(busy_w[0]), 32'd0);
        chk("hold_gap_done", p, 32'(done_w[0]), 32'd1);
      end
      if (p < 50 && done_w[0] === 1'b1) done_cnt++;
      @(negedge clk);
    end
    start_s[0] = 1'b0;
    chk("hold_done_count", 0, 32'(done_cnt), 32'd2);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (done_w[0] === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    chk("hold_drain_done", 0, 32'(seen), 32'd1);
    chk("hold_drain_busy", 0, 32'(busy_w[0]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
